// File: rtl/fetch_ibuf.sv
// fetch_ibuf: four-slot instruction line buffer between the I-cache fill path
// and the fetch_2 packet aligner.
//
// Ports
//   clk, reset        rising-edge clock, synchronous active-high reset
//   fill_line         16-byte I-cache line, memory byte order
//   fill_valid        fill_line presented this cycle
//   fill_epoch        epoch tag of the presented fill
//   fill_ready        buffer accepts a fill this cycle (combinational)
//   old_BIP, new_BIP  byte pointers of current / next packet from fetch_2
//   packet_consumed   fetch_2 packet valid and not stalled this cycle
//   flush, flush_BIP  control-flow redirect and its target byte pointer
//   line_00..line_11  slot data; slot n holds lines with BIP[5:4]==n
//   line_xx_valid     slot holds live data
//   cur_epoch         current epoch, returned to the I-cache request side
//   occupancy         number of valid slots, 0..4
module fetch_ibuf #(
  parameter int DATA_W = 128
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] fill_line,
  input  logic              fill_valid,
  input  logic              fill_epoch,
  output logic              fill_ready,
  input  logic [5:0]        old_BIP,
  input  logic [5:0]        new_BIP,
  input  logic              packet_consumed,
  input  logic              flush,
  input  logic [5:0]        flush_BIP,
  output logic [DATA_W-1:0] line_00,
  output logic [DATA_W-1:0] line_01,
  output logic [DATA_W-1:0] line_10,
  output logic [DATA_W-1:0] line_11,
  output logic              line_00_valid,
  output logic              line_01_valid,
  output logic              line_10_valid,
  output logic              line_11_valid,
  output logic              cur_epoch,
  output logic [2:0]        occupancy
);

  logic [DATA_W-1:0] slot_q [4];
  logic [3:0]        valid_q;
  logic [1:0]        wr_ptr_q;
  logic              epoch_q;
  logic [2:0]        occ_q;

  logic              fill_acc;
  logic              fill_wr;
  logic              release_en;
  logic [3:0]        valid_nxt;

  // Byte offsets within a line do not affect buffer state.
  logic unused_offsets;
  assign unused_offsets = ^{old_BIP[3:0], new_BIP[3:0], flush_BIP[3:0]};

  function automatic logic [2:0] popcount4(input logic [3:0] v);
    popcount4 = {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
  endfunction

  // A stale-epoch fill is always accepted so the cache side can drain it,
  // even when the target slot is still occupied.
  assign fill_ready = (!valid_q[wr_ptr_q] || (fill_epoch != epoch_q)) && !flush && !reset;
  assign fill_acc   = fill_valid && fill_ready;
  assign fill_wr    = fill_acc && (fill_epoch == epoch_q);
  assign release_en = packet_consumed && (old_BIP[5:4] != new_BIP[5:4]);

  // The released slot is never wr_ptr when a fill is written (the fill target
  // must be empty, the released slot is live), so clear-then-set is safe.
  always_comb begin
    valid_nxt = valid_q;
    if (flush) begin
      valid_nxt = 4'b0000;
    end else begin
      if (release_en) valid_nxt[old_BIP[5:4]] = 1'b0;
      if (fill_wr)    valid_nxt[wr_ptr_q]     = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) slot_q[i] <= '0;
      valid_q  <= 4'b0000;
      wr_ptr_q <= 2'd0;
      epoch_q  <= 1'b0;
      occ_q    <= 3'd0;
    end else begin
      valid_q <= valid_nxt;
      occ_q   <= popcount4(valid_nxt);
      if (flush) begin
        wr_ptr_q <= flush_BIP[5:4];
        epoch_q  <= ~epoch_q;
      end else if (fill_wr) begin
        slot_q[wr_ptr_q] <= fill_line;
        wr_ptr_q         <= wr_ptr_q + 2'd1;
      end
    end
  end

  assign line_00       = slot_q[0];
  assign line_01       = slot_q[1];
  assign line_10       = slot_q[2];
  assign line_11       = slot_q[3];
  assign line_00_valid = valid_q[0];
  assign line_01_valid = valid_q[1];
  assign line_10_valid = valid_q[2];
  assign line_11_valid = valid_q[3];
  assign cur_epoch     = epoch_q;
  assign occupancy     = occ_q;

endmodule

// File: tb/tb_fetch_ibuf.sv
module tb_fetch_ibuf;

  logic         clk = 1'b0;
  logic         reset;
  logic [127:0] fill_line;
  logic         fill_valid;
  logic         fill_epoch;
  logic         fill_ready;
  logic [5:0]   old_BIP;
  logic [5:0]   new_BIP;
  logic         packet_consumed;
  logic         flush;
  logic [5:0]   flush_BIP;
  logic [127:0] line_00, line_01, line_10, line_11;
  logic         line_00_valid, line_01_valid, line_10_valid, line_11_valid;
  logic         cur_epoch;
  logic [2:0]   occupancy;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  logic [127:0] m_slot [4];
  bit           m_val  [4];
  int           m_wp;
  bit           m_ep;

  logic [127:0] ref_e;

  always #5 clk = ~clk;

  fetch_ibuf dut (
    .clk(clk), .reset(reset),
    .fill_line(fill_line), .fill_valid(fill_valid), .fill_epoch(fill_epoch),
    .fill_ready(fill_ready),
    .old_BIP(old_BIP), .new_BIP(new_BIP), .packet_consumed(packet_consumed),
    .flush(flush), .flush_BIP(flush_BIP),
    .line_00(line_00), .line_01(line_01), .line_10(line_10), .line_11(line_11),
    .line_00_valid(line_00_valid), .line_01_valid(line_01_valid),
    .line_10_valid(line_10_valid), .line_11_valid(line_11_valid),
    .cur_epoch(cur_epoch), .occupancy(occupancy)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] rnd_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic bit model_ready();
    if (reset || flush) return 1'b0;
    return (!m_val[m_wp]) || (fill_epoch != m_ep);
  endfunction

  function automatic int model_occ();
    int c = 0;
    for (int i = 0; i < 4; i++) c += m_val[i];
    return c;
  endfunction

  // One clock edge of the buffer, expressed from the behavioural rules.
  task automatic model_update(input bit rdy);
    int os, ns;
    os = int'(old_BIP) / 16;
    ns = int'(new_BIP) / 16;
    if (reset) begin
      for (int i = 0; i < 4; i++) begin m_slot[i] = '0; m_val[i] = 0; end
      m_wp = 0; m_ep = 0;
    end else if (flush) begin
      for (int i = 0; i < 4; i++) m_val[i] = 0;
      m_wp = int'(flush_BIP) / 16;
      m_ep = !m_ep;
    end else begin
      if (packet_consumed && os != ns) m_val[os] = 0;
      if (fill_valid && rdy && fill_epoch == m_ep) begin
        m_slot[m_wp] = fill_line;
        m_val[m_wp]  = 1;
        m_wp = (m_wp + 1) % 4;
      end
    end
  endtask

  task automatic check_all();
    chk("line_00", line_00, m_slot[0]);
    chk("line_01", line_01, m_slot[1]);
    chk("line_10", line_10, m_slot[2]);
    chk("line_11", line_11, m_slot[3]);
    chk("valid_00", line_00_valid, m_val[0]);
    chk("valid_01", line_01_valid, m_val[1]);
    chk("valid_10", line_10_valid, m_val[2]);
    chk("valid_11", line_11_valid, m_val[3]);
    chk("cur_epoch", cur_epoch, m_ep);
    chk("occupancy", occupancy, 128'(model_occ()));
  endtask

  task automatic idle();
    reset = 0; fill_valid = 0; fill_epoch = 0; fill_line = '0;
    old_BIP = 0; new_BIP = 0; packet_consumed = 0; flush = 0; flush_BIP = 0;
  endtask

  // Called just after a negedge with inputs set; returns just after the next negedge.
  task automatic cycle();
    bit rdy;
    #1;
    rdy = model_ready();
    chk("fill_ready", fill_ready, rdy);
    @(posedge clk);
    model_update(rdy);
    #1;
    check_all();
    @(negedge clk);
  endtask

  task automatic do_fill(input logic [127:0] d, input bit ep);
    idle();
    fill_valid = 1; fill_line = d; fill_epoch = ep;
    cycle();
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin m_slot[i] = 'x; m_val[i] = 0; end
    m_wp = 0; m_ep = 0;
    idle();
    @(negedge clk);

    // Reset with a fill presented: nothing accepted, everything cleared
    reset = 1; fill_valid = 1; fill_line = rnd_line();
    cycle();
    cycle();
    chk("rst_occ", occupancy, 0);
    chk("rst_line_00", line_00, 0);

    // Four fills A..D into slots 00..11
    for (int i = 0; i < 4; i++) do_fill(rnd_line(), 1'b0);
    chk("full_valids", {line_11_valid, line_10_valid, line_01_valid, line_00_valid}, 4'b1111);
    chk("full_occ", occupancy, 4);
    idle(); fill_valid = 1; fill_line = rnd_line();
    #1;
    chk("full_ready", fill_ready, 0);

    // Release slot 00 while full; fill_ready stays low that cycle
    idle();
    packet_consumed = 1; old_BIP = 6'h0E; new_BIP = 6'h13;
    fill_valid = 1; fill_line = rnd_line();
    cycle();
    chk("rel_valid_00", line_00_valid, 0);
    chk("rel_occ", occupancy, 3);
    ref_e = rnd_line();
    idle(); fill_valid = 1; fill_line = ref_e;
    #1;
    chk("rel_ready_next", fill_ready, 1);
    cycle();
    chk("fill_E_slot00", line_00, ref_e);

    // Wrap from slot 11 to 00 releases 11 and leaves 00 alone
    idle();
    packet_consumed = 1; old_BIP = 6'h3C; new_BIP = 6'h02;
    cycle();
    chk("wrap_valid_11", line_11_valid, 0);
    chk("wrap_line_00", line_00, ref_e);
    chk("wrap_valid_00", line_00_valid, 1);

    // Flush with simultaneous fill and crossing release
    idle();
    flush = 1; flush_BIP = 6'h25;
    fill_valid = 1; fill_line = rnd_line();
    packet_consumed = 1; old_BIP = 6'h12; new_BIP = 6'h21;
    #1;
    chk("flush_ready", fill_ready, 0);
    cycle();
    chk("flush_valids", {line_11_valid, line_10_valid, line_01_valid, line_00_valid}, 4'b0000);
    chk("flush_occ", occupancy, 0);
    chk("flush_epoch", cur_epoch, 1);

    // Stale epoch-0 fill: accepted and dropped
    idle(); fill_valid = 1; fill_epoch = 0; fill_line = rnd_line();
    #1;
    chk("stale_ready", fill_ready, 1);
    cycle();
    chk("stale_occ", occupancy, 0);

    // Epoch-1 fill lands in slot 10, then two more wrap through 11 to 00
    ref_e = rnd_line();
    do_fill(ref_e, 1'b1);
    chk("epoch1_slot10", line_10, ref_e);
    chk("epoch1_valid10", line_10_valid, 1);
    do_fill(rnd_line(), 1'b1);
    do_fill(rnd_line(), 1'b1);
    chk("three_occ", occupancy, 3);

    // Reset with three valid slots and a fill presented
    idle(); reset = 1; fill_valid = 1; fill_epoch = 1; fill_line = rnd_line();
    cycle();
    chk("rst2_occ", occupancy, 0);
    chk("rst2_epoch", cur_epoch, 0);
    chk("rst2_line_10", line_10, 0);

    // First cycle after reset accepts epoch 0 into slot 00
    ref_e = rnd_line();
    do_fill(ref_e, 1'b0);
    chk("post_rst_slot00", line_00, ref_e);

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      idle();
      reset           = ($urandom_range(0, 99) < 2);
      flush           = ($urandom_range(0, 99) < 6);
      flush_BIP       = 6'($urandom_range(0, 63));
      fill_valid      = ($urandom_range(0, 99) < 60);
      fill_line       = rnd_line();
      fill_epoch      = ($urandom_range(0, 3) == 0) ? !m_ep : m_ep;
      packet_consumed = ($urandom_range(0, 99) < 50);
      old_BIP         = 6'($urandom_range(0, 63));
      new_BIP         = 6'((int'(old_BIP) + $urandom_range(0, 15)) % 64);
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_ibuf.md
FETCH_IBUF -- requirements
Module: fetch_ibuf

Interface
REQ-001 SHALL have one clock; reset is synchronous and active-high. Ports: clk, reset.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 fill_line  in  128  one 16-byte I-cache line, in memory byte order.
REQ-005 fill_valid  in  1  fill_line is presented this cycle.
REQ-006 fill_epoch  in  1  epoch tag of the presented fill.
REQ-007 fill_ready  out  1  buffer accepts a fill this cycle.
REQ-008 old_BIP  in  6  byte pointer of the packet currently being decoded, taken from fetch_2.
REQ-009 new_BIP  in  6  byte pointer of the next packet, taken from fetch_2.
REQ-010 packet_consumed  in  1  the fetch_2 packet was valid and not stalled this cycle.
REQ-011 flush  in  1  control-flow redirect (init, resteer, or taken branch).
REQ-012 flush_BIP  in  6  redirect target BIP.
REQ-013 line_00, line_01, line_10, line_11  out  128 each  slot data; slot n holds BIP[5:4]==n.
REQ-014 line_00_valid .. line_11_valid  out  1 each  slot holds live data.
REQ-015 cur_epoch  out  1  current epoch, sent to the I-cache request side.
REQ-016 occupancy  out  3  count of valid slots, 0..4.

Function
REQ-017 SHALL keep four 128-bit slots, a valid bit per slot, a 2-bit write pointer wr_ptr, and a 1-bit epoch.
REQ-018 Fill acceptance SHALL occur when fill_valid & fill_ready are both high on a clock edge.
REQ-019 fill_ready SHALL equal (!valid[wr_ptr] | fill_epoch!=cur_epoch) & !flush & !reset.
REQ-020 Accepted fill with fill_epoch==cur_epoch: on the next edge, write slot[wr_ptr]=fill_line, set valid[wr_ptr]=1, wr_ptr+=1 (mod 4; 11 wraps to 00).
REQ-021 Accepted fill with fill_epoch!=cur_epoch: discard it; no slot, valid, or wr_ptr change.
REQ-022 Release: when packet_consumed=1 and old_BIP[5:4]!=new_BIP[5:4], clear valid[old_BIP[5:4]] on the next edge. Slot data is unchanged.
REQ-023 A packet SHALL cross at most one line boundary; wrap from slot 11 to slot 00 releases slot 11.
REQ-024 Release and fill in the same cycle: both take effect. The released slot is always a different slot from wr_ptr, so there is no conflict.
REQ-025 Release when the buffer is full makes fill_ready high in the following cycle, not the same cycle.
REQ-026 Flush: on the next edge clear all four valid bits, set wr_ptr=flush_BIP[5:4], toggle epoch. Fill and release are ignored that cycle.
REQ-027 Flush SHALL NOT modify slot data.
REQ-028 occupancy SHALL be the registered popcount of the valid bits, updated in the same edge as the valids.
REQ-029 All outputs SHALL be driven directly from registers, except fill_ready.
REQ-030 Latency: an accepted fill is visible on line_xx/line_xx_valid one cycle after acceptance.
REQ-031 Slot data SHALL be stored in memory byte order; byte reversal and rotation are fetch_2's job.

Reset
REQ-032 reset SHALL take priority over flush, fill and release.
REQ-033 On reset: all valid=0, all slot data=0, wr_ptr=0, epoch=0, occupancy=0, fill_ready=0 while reset is high.
REQ-034 The first cycle after reset deasserts SHALL accept a fill into slot 00 with epoch 0.
REQ-035 reset asserted mid-fill or mid-flush SHALL fully discard that operation.

Verification
REQ-036 Reset, then 4 fills A,B,C,D with epoch 0 -> line_00..11=A..D, valids=1111, occupancy=4, fill_ready=0.
REQ-037 Full buffer, packet_consumed with old_BIP=0x0E, new_BIP=0x13 -> line_00_valid=0 and occupancy=3 next cycle; fill_ready=1 the cycle after the release; next fill E lands in slot 00.
REQ-038 Wrap: old_BIP=0x3C, new_BIP=0x02, packet_consumed=1 -> line_11_valid=0, slot 00 untouched.
REQ-039 flush with flush_BIP=0x25 -> valids=0000, occupancy=0, cur_epoch toggles 0->1; the next epoch-1 fill lands in slot 10; an epoch-0 fill arriving after the flush is accepted and discarded with no state change.
REQ-040 Same cycle flush + fill_valid + packet_consumed crossing a line -> only the flush takes effect; fill_ready=0 that cycle.
REQ-041 reset asserted while the buffer holds 3 valid slots and a fill is presented -> all REQ-033 values next cycle; the fill is not written.
